render_slave_regs: RTL and testbench
====================================

// Module: render_slave_regs
// PURPOSE
// - Avalon-MM slave register front end of the renderer; responds to the CPU/test master driving slave_*.
// - Latches X, Y and TEXTURE registers; a write to PLOT snapshots them into a command FIFO.
// - Hands commands to the pixel drawer over valid/ready; counts completed draws; exposes busy/full status.
// - Sits between the HPS/test-master bus and the drawer/VGA path inside the render top level.
// PARAMETERS
// CMD_DEPTH  4  command FIFO entries (power of 2, >=2)
// X_W        9  x coordinate width (0..319)
// Y_W        8  y coordinate width (0..239)
// TEX_W      7  texture code width
// PORTS
// clk               in   1      system clock (single clock domain)
// rst_n             in   1      reset: one clock; reset is synchronous and active-high
// slave_address     in   4      register word address
// slave_read        in   1      read strobe
// slave_readdata    out  32     read data; valid when slave_read=1 and slave_waitrequest=0
// slave_write       in   1      write strobe
// slave_writedata   in   32     write data
// slave_waitrequest out  1      stall current access
// cmd_valid         out  1      FIFO head valid
// cmd_ready         in   1      drawer accepts head
// cmd_x             out  X_W    head x
// cmd_y             out  Y_W    head y
// cmd_texture       out  TEX_W  head texture code
// draw_busy         in   1      drawer executing a command
// draw_done         in   1      one-cycle pulse: drawer finished a command
// BEHAVIOUR
// - Register map (word addr): 0 STATUS RO {16'b0, done_cnt[7:0], 6'b0, full, busy}; 1 X RW; 2 Y RW;
//   4 TEXTURE RW; 6 PLOT WO (data ignored); 7 DONE_CLR WO; 3,5,8-15 reserved: read 0, writes ignored.
// - RW regs store low X_W/Y_W/TEX_W bits of writedata, no clamping; readback zero-extended. PLOT/DONE_CLR read 0.
// - Reads: zero wait state; slave_readdata combinational from current regs; 0 when slave_read=0.
// - slave_waitrequest = rst_n | (slave_write & address==6 & full). All other accesses never stall.
// - Write accepted on clock edge where slave_write=1 and slave_waitrequest=0; register updates visible next cycle.
// - PLOT accept: push {TEXTURE, X, Y} as held before that edge; master's stalled PLOT completes once full clears.
// - FIFO: cmd_valid = ~empty; cmd_x/y/texture = head entry, stable while cmd_valid & ~cmd_ready.
//   Pop on cmd_valid & cmd_ready. Push+pop same cycle: occupancy unchanged, order preserved.
//   full = occupancy==CMD_DEPTH; push while full cannot occur (stalled). Pop from empty impossible (valid low).
// - busy = ~empty | draw_busy. done_cnt: +1 per draw_done pulse, wraps 255->0.
//   DONE_CLR write and draw_done same cycle -> done_cnt = 1.
// - Reset (sampled high on edge): X=Y=TEXTURE=0, FIFO empty (queued commands discarded), done_cnt=0,
//   cmd_valid=0 from next cycle; waitrequest=1 throughout reset. Mid-handshake reset drops head; drawer must tolerate.
// - Outputs after reset: slave_readdata=0 (no read), cmd_valid=0, cmd_x/y/texture=0, slave_waitrequest=0.
// TESTING
// 1 Reset, write X=159, Y=119, TEX=7'b0000101, PLOT, cmd_ready=1 -> one cmd_valid beat {159,119,5}; STATUS busy then 0.
// 2 TEX=7'b0111100 then PLOT with X/Y at reset -> cmd {0,0,60}; readback X=0,Y=0,TEX=60 zero-extended.
// 3 cmd_ready=0, 5 PLOTs (CMD_DEPTH=4) -> 5th stalls with waitrequest=1, STATUS full=1; raise cmd_ready -> 5th
//   accepted, all 5 emerge in order.
// 4 Write X=0x3FF_FFFF -> reads back 0x1FF; write to addr 5 then read -> 0; read PLOT -> 0.
// 5 256 draw_done pulses -> done_cnt wraps to 0; DONE_CLR with simultaneous draw_done -> done_cnt=1.
// 6 Queue 3 commands, assert rst_n mid-handshake -> cmd_valid=0 next cycle, waitrequest=1 during reset, regs=0 after.

Source files
------------

// File: rtl/render_slave_regs.sv
// Avalon-MM register front end of the renderer: X/Y/TEXTURE latches, PLOT command FIFO
// feeding the pixel drawer over valid/ready, completed-draw counter and busy/full status.
module render_slave_regs #(
   parameter int CMD_DEPTH = 4,
   parameter int X_W       = 9,
   parameter int Y_W       = 8,
   parameter int TEX_W     = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       slave_address,
   input  logic             slave_read,
   output logic [31:0]      slave_readdata,
   input  logic             slave_write,
   input  logic [31:0]      slave_writedata,
   output logic             slave_waitrequest,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [X_W-1:0]   cmd_x,
   output logic [Y_W-1:0]   cmd_y,
   output logic [TEX_W-1:0] cmd_texture,
   input  logic             draw_busy,
   input  logic             draw_done
);
   localparam int AW = $clog2(CMD_DEPTH);
   localparam int CW = TEX_W + X_W + Y_W;

   logic [X_W-1:0]   x_reg;
   logic [Y_W-1:0]   y_reg;
   logic [TEX_W-1:0] tex_reg;
   logic [7:0]       done_cnt;
   logic [CW-1:0]    fifo_mem [CMD_DEPTH];
   logic [CW-1:0]    head;
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             empty, full, busy;
   logic             wr_accept, push, pop, done_clr;
   logic             unused_wdata;

   assign unused_wdata = ^slave_writedata;

   // Extra pointer bit distinguishes full from empty when the indices coincide.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign busy  = ~empty | draw_busy;

   assign slave_waitrequest = rst_n | (slave_write & (slave_address == 4'd6) & full);
   assign wr_accept = slave_write & ~slave_waitrequest;
   assign push      = wr_accept & (slave_address == 4'd6);
   assign done_clr  = wr_accept & (slave_address == 4'd7);
   assign pop       = cmd_valid & cmd_ready;

   assign head        = fifo_mem[rd_ptr[AW-1:0]];
   assign cmd_valid   = ~empty;
   assign cmd_texture = empty ? '0 : head[CW-1 -: TEX_W];
   assign cmd_x       = empty ? '0 : head[X_W+Y_W-1 -: X_W];
   assign cmd_y       = empty ? '0 : head[Y_W-1:0];

   always_ff @(posedge clk) begin
      if (rst_n) begin
         x_reg    <= '0;
         y_reg    <= '0;
         tex_reg  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         done_cnt <= '0;
      end else begin
         if (wr_accept) begin
            case (slave_address)
               4'd1:    x_reg   <= slave_writedata[X_W-1:0];
               4'd2:    y_reg   <= slave_writedata[Y_W-1:0];
               4'd4:    tex_reg <= slave_writedata[TEX_W-1:0];
               default: ;
            endcase
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         // A clear racing a completion keeps that completion.
         if (done_clr)       done_cnt <= {7'd0, draw_done};
         else if (draw_done) done_cnt <= done_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= {tex_reg, x_reg, y_reg};
   end

   always_comb begin
      slave_readdata = '0;
      if (slave_read) begin
         case (slave_address)
            4'd0:    slave_readdata = {16'b0, done_cnt, 6'b0, full, busy};
            4'd1:    slave_readdata = {{(32-X_W){1'b0}}, x_reg};
            4'd2:    slave_readdata = {{(32-Y_W){1'b0}}, y_reg};
            4'd4:    slave_readdata = {{(32-TEX_W){1'b0}}, tex_reg};
            default: slave_readdata = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_render_slave_regs.sv
// Directed bench for render_slave_regs: queue-based reference model checked every cycle,
// plus literal expectations on drawer beats and register readbacks.
module tb_render_slave_regs;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  slave_address = '0;
   logic        slave_read = 1'b0;
   logic [31:0] slave_readdata;
   logic        slave_write = 1'b0;
   logic [31:0] slave_writedata = '0;
   logic        slave_waitrequest;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [8:0]  cmd_x;
   logic [7:0]  cmd_y;
   logic [6:0]  cmd_texture;
   logic        draw_busy = 1'b0;
   logic        draw_done = 1'b0;

   render_slave_regs dut (
      .clk(clk), .rst_n(rst_n),
      .slave_address(slave_address), .slave_read(slave_read), .slave_readdata(slave_readdata),
      .slave_write(slave_write), .slave_writedata(slave_writedata),
      .slave_waitrequest(slave_waitrequest),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_texture(cmd_texture),
      .draw_busy(draw_busy), .draw_done(draw_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: register values, queue of pending commands {tex,x,y}, completion count.
   int          m_x = 0, m_y = 0, m_tex = 0, m_done = 0;
   logic [23:0] m_q[$];
   logic [23:0] beats[$];
   bit          chk_en = 1'b0;

   function automatic logic [31:0] m_read();
      int full, busy;
      if (!slave_read) return 32'd0;
      full = (m_q.size() == 4);
      busy = (m_q.size() != 0 || draw_busy) ? 1 : 0;
      case (slave_address)
         4'd0:    return 32'(m_done * 256 + full * 2 + busy);
         4'd1:    return 32'(m_x);
         4'd2:    return 32'(m_y);
         4'd4:    return 32'(m_tex);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_wait();
      return rst_n | (slave_write & (slave_address == 4'd6) & (m_q.size() == 4));
   endfunction

   always @(posedge clk) begin
      bit acc;
      if (rst_n) begin
         m_x = 0; m_y = 0; m_tex = 0; m_done = 0;
         m_q.delete();
         chk_en = 1'b1;
      end else begin
         acc = slave_write & ~m_wait();
         if (cmd_valid && cmd_ready) beats.push_back({cmd_texture, cmd_x, cmd_y});
         if (m_q.size() != 0 && cmd_ready) void'(m_q.pop_front());
         if (acc && slave_address == 4'd6) m_q.push_back({7'(m_tex), 9'(m_x), 8'(m_y)});
         if (acc && slave_address == 4'd1) m_x = int'(slave_writedata % 512);
         if (acc && slave_address == 4'd2) m_y = int'(slave_writedata % 256);
         if (acc && slave_address == 4'd4) m_tex = int'(slave_writedata % 128);
         if (acc && slave_address == 4'd7) m_done = draw_done ? 1 : 0;
         else if (draw_done) m_done = (m_done + 1) % 256;
      end
   end

   always @(negedge clk) begin
      logic [23:0] hd;
      if (chk_en) begin
         hd = (m_q.size() != 0) ? m_q[0] : 24'd0;
         checks++;
         if (cmd_valid !== (m_q.size() != 0)) begin
            errors++; $display("FAIL cmd_valid: got %b want %b at %0t", cmd_valid, m_q.size() != 0, $time);
         end
         checks++;
         if ({cmd_texture, cmd_x, cmd_y} !== hd) begin
            errors++; $display("FAIL cmd_head: got %h want %h at %0t", {cmd_texture, cmd_x, cmd_y}, hd, $time);
         end
         checks++;
         if (slave_waitrequest !== m_wait()) begin
            errors++; $display("FAIL waitrequest: got %b want %b at %0t", slave_waitrequest, m_wait(), $time);
         end
         checks++;
         if (slave_readdata !== m_read()) begin
            errors++; $display("FAIL readdata: got %h want %h at %0t", slave_readdata, m_read(), $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++; $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      bit w;
      int n = 0;
      slave_address = a; slave_writedata = d; slave_write = 1'b1;
      do begin
         #1 w = slave_waitrequest;
         tick();
         n++;
      end while (w && n < 50);
      if (w) begin
         errors++; checks++; $display("FAIL write_timeout: addr %0d still stalled want accepted", a);
      end
      slave_write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      slave_address = a; slave_read = 1'b1;
      #1 d = slave_readdata;
      tick();
      slave_read = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b1; tick(); tick(); rst_n = 1'b0; #1;
   endtask

   logic [31:0] r;
   int base;

   initial begin
      #1;
      do_reset();
      chk("reset_wait", 32'(slave_waitrequest), 32'd0);
      chk("reset_valid", 32'(cmd_valid), 32'd0);
      rd(4'd0, r); chk("reset_status", r, 32'h0);

      // 1: single command
      wr(4'd1, 159); wr(4'd2, 119); wr(4'd4, 32'h05);
      wr(4'd6, 32'hDEAD);
      rd(4'd0, r); chk("t1_status_busy", r, 32'h1);
      cmd_ready = 1'b1; tick(); tick();
      rd(4'd0, r); chk("t1_status_idle", r, 32'h0);
      chk("t1_nbeats", 32'(beats.size()), 32'd1);
      chk("t1_beat", 32'(beats[0]), 32'({7'd5, 9'd159, 8'd119}));
      draw_busy = 1'b1;
      rd(4'd0, r); chk("t1_draw_busy", r, 32'h1);
      draw_busy = 1'b0;

      // 2: plot with X/Y at reset values
      do_reset();
      wr(4'd4, 32'h3C); wr(4'd6, 0); tick(); tick();
      chk("t2_beat", 32'(beats[1]), 32'({7'd60, 9'd0, 8'd0}));
      rd(4'd1, r); chk("t2_x", r, 32'd0);
      rd(4'd2, r); chk("t2_y", r, 32'd0);
      rd(4'd4, r); chk("t2_tex", r, 32'd60);

      // 3: fill the FIFO, stall the fifth PLOT
      cmd_ready = 1'b0;
      base = beats.size();
      for (int i = 0; i < 4; i++) begin
         wr(4'd1, 10 + i); wr(4'd6, 0);
      end
      rd(4'd0, r); chk("t3_status_full", r, 32'h3);
      wr(4'd1, 14);
      slave_address = 4'd6; slave_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t3_stall", 32'(slave_waitrequest), 32'd1);
         tick();
      end
      cmd_ready = 1'b1;
      wr(4'd6, 0);
      repeat (8) tick();
      chk("t3_nbeats", 32'(beats.size() - base), 32'd5);
      for (int i = 0; i < 5; i++)
         chk("t3_order", 32'(beats[base + i]), 32'({7'd60, 9'(10 + i), 8'd0}));

      // 4: truncation and reserved / write-only addresses
      wr(4'd1, 32'h3FF_FFFF);
      rd(4'd1, r); chk("t4_x_trunc", r, 32'h1FF);
      wr(4'd5, 32'h1234);
      rd(4'd5, r); chk("t4_reserved", r, 32'd0);
      rd(4'd6, r); chk("t4_plot_read", r, 32'd0);
      rd(4'd7, r); chk("t4_clr_read", r, 32'd0);

      // 5: done counter wrap and clear-vs-done collision
      draw_done = 1'b1;
      repeat (3) tick();
      draw_done = 1'b0;
      rd(4'd0, r); chk("t5_cnt3", r, 32'h300);
      draw_done = 1'b1;
      repeat (253) tick();
      draw_done = 1'b0;
      rd(4'd0, r); chk("t5_wrap", r, 32'h0);
      draw_done = 1'b1; repeat (2) tick(); draw_done = 1'b0;
      draw_done = 1'b1; wr(4'd7, 0); draw_done = 1'b0;
      rd(4'd0, r); chk("t5_clr_done", r, 32'h100);
      wr(4'd7, 0);
      rd(4'd0, r); chk("t5_clr", r, 32'h0);

      // 6: reset while commands are queued and head is offered
      cmd_ready = 1'b0;
      wr(4'd2, 77); wr(4'd4, 9);
      for (int i = 0; i < 3; i++) wr(4'd6, 0);
      chk("t6_valid_before", 32'(cmd_valid), 32'd1);
      cmd_ready = 1'b1; rst_n = 1'b1;
      tick();
      chk("t6_valid_after", 32'(cmd_valid), 32'd0);
      chk("t6_wait_in_reset", 32'(slave_waitrequest), 32'd1);
      tick();
      rst_n = 1'b0; #1;
      chk("t6_wait_after", 32'(slave_waitrequest), 32'd0);
      rd(4'd2, r); chk("t6_y", r, 32'd0);
      rd(4'd4, r); chk("t6_tex", r, 32'd0);
      rd(4'd0, r); chk("t6_status", r, 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish want finish");
      $fatal(1);
   end
endmodule
